// File: rtl/core_wb_arbiter.sv
// core_wb_arbiter: round-robin write-back arbiter with registered regfile write port and pending-write scoreboard.
// Define CORE_WB_BYPASS_EN to add rs1_byp/rs2_byp/byp_dat forwarding from the write port.
module core_wb_arbiter #(
  parameter int NREQ    = 3,
  parameter int XLEN    = 32,
  parameter int RFIDX_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*RFIDX_W-1:0] req_idx,
  input  logic [NREQ*XLEN-1:0]    req_dat,
  output logic [NREQ-1:0]         req_ready,
  output logic                    wb_dest_wen,
  output logic [RFIDX_W-1:0]      wb_dest_idx,
  output logic [XLEN-1:0]         wb_dest_dat,
  input  logic                    iss_valid,
  input  logic [RFIDX_W-1:0]      iss_idx,
  output logic                    iss_waw,
  input  logic                    sb_flush,
  input  logic [RFIDX_W-1:0]      rs1_idx,
  input  logic [RFIDX_W-1:0]      rs2_idx,
  output logic                    rs1_busy,
  output logic                    rs2_busy
`ifdef CORE_WB_BYPASS_EN
  ,
  output logic                    rs1_byp,
  output logic                    rs2_byp,
  output logic [XLEN-1:0]         byp_dat
`endif
);
  localparam int PW = $clog2(NREQ);
  localparam int NR = 2**RFIDX_W;
  logic [PW-1:0]      rr_ptr, g_sel;
  logic [PW:0]        s;
  logic [NREQ-1:0]    rot;
  logic               any;
  logic [RFIDX_W-1:0] g_idx;
  logic [XLEN-1:0]    g_dat;
  logic [NR-1:0]      sb;
  // rotate so bit 0 is the requester at rr_ptr; first set bit wins
  assign rot = NREQ'({req_valid, req_valid} >> rr_ptr);
  always_comb begin
    any = 1'b0;
    s   = '0;
    for (int k = 0; k < NREQ; k++)
      if (!any && rot[k]) begin
        any = 1'b1;
        s   = (PW+1)'(rr_ptr) + (PW+1)'(k);
      end
  end
  assign g_sel     = s >= (PW+1)'(NREQ) ? PW'(s - (PW+1)'(NREQ)) : PW'(s);
  assign req_ready = any ? NREQ'(1) << g_sel : '0;
  assign g_idx     = req_idx[g_sel*RFIDX_W +: RFIDX_W];
  assign g_dat     = req_dat[g_sel*XLEN +: XLEN];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wb_dest_wen <= 1'b0;
      wb_dest_idx <= '0;
      wb_dest_dat <= '0;
      rr_ptr      <= '0;
    end else begin
      wb_dest_wen <= any && g_idx != '0;
      if (any) begin
        wb_dest_idx <= g_idx;
        wb_dest_dat <= g_dat;
        rr_ptr      <= g_sel == PW'(NREQ-1) ? '0 : g_sel + 1'b1;
      end
    end
  // issue is written after the clear so a same-edge set to the same index wins
  always_ff @(posedge clk or posedge rst)
    if (rst) sb <= '0;
    else if (sb_flush) sb <= '0;
    else begin
      if (wb_dest_wen) sb[wb_dest_idx] <= 1'b0;
      if (iss_valid && iss_idx != '0) sb[iss_idx] <= 1'b1;
    end
  assign iss_waw = sb[iss_idx];
`ifdef CORE_WB_BYPASS_EN
  assign rs1_byp  = wb_dest_wen && wb_dest_idx == rs1_idx && rs1_idx != '0;
  assign rs2_byp  = wb_dest_wen && wb_dest_idx == rs2_idx && rs2_idx != '0;
  assign byp_dat  = wb_dest_dat;
  assign rs1_busy = sb[rs1_idx] & ~rs1_byp;
  assign rs2_busy = sb[rs2_idx] & ~rs2_byp;
`else
  assign rs1_busy = sb[rs1_idx];
  assign rs2_busy = sb[rs2_idx];
`endif
endmodule

// File: tb/tb_core_wb_arbiter.sv
// tb_core_wb_arbiter: directed and random checks of core_wb_arbiter against a behavioural model.
// Honours CORE_WB_BYPASS_EN when the design is built with it.
module tb_core_wb_arbiter;
  localparam int NREQ = 3;
  localparam int XLEN = 32;
  localparam int RW   = 5;
  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*RW-1:0] req_idx;
  logic [NREQ*XLEN-1:0] req_dat;
  logic [NREQ-1:0]    req_ready;
  logic               wb_dest_wen;
  logic [RW-1:0]      wb_dest_idx;
  logic [XLEN-1:0]    wb_dest_dat;
  logic               iss_valid;
  logic [RW-1:0]      iss_idx;
  logic               iss_waw;
  logic               sb_flush;
  logic [RW-1:0]      rs1_idx, rs2_idx;
  logic               rs1_busy, rs2_busy;
`ifdef CORE_WB_BYPASS_EN
  logic               rs1_byp, rs2_byp;
  logic [XLEN-1:0]    byp_dat;
`endif

  always #5 clk = ~clk;

  core_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .RFIDX_W(RW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_idx(req_idx), .req_dat(req_dat), .req_ready(req_ready),
    .wb_dest_wen(wb_dest_wen), .wb_dest_idx(wb_dest_idx), .wb_dest_dat(wb_dest_dat),
    .iss_valid(iss_valid), .iss_idx(iss_idx), .iss_waw(iss_waw), .sb_flush(sb_flush),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
`ifdef CORE_WB_BYPASS_EN
    , .rs1_byp(rs1_byp), .rs2_byp(rs2_byp), .byp_dat(byp_dat)
`endif
  );

  int passed = 0;
  int total  = 0;
  bit          sb_m [32];
  int          rr;
  logic        m_wen;
  logic [4:0]  m_idx;
  logic [31:0] m_dat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    foreach (sb_m[i]) sb_m[i] = 1'b0;
    rr = 0; m_wen = 1'b0; m_idx = '0; m_dat = '0;
  endtask

  function automatic int exp_gnt();
    for (int o = 0; o < NREQ; o++)
      if (req_valid[(rr + o) % NREQ]) return (rr + o) % NREQ;
    return -1;
  endfunction

  function automatic bit exp_byp(input logic [4:0] r);
`ifdef CORE_WB_BYPASS_EN
    return m_wen && m_idx == r && r != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_busy(input logic [4:0] r);
    return r != 0 && sb_m[r] && !exp_byp(r);
  endfunction

  // called just after a negedge with inputs driven; returns the expected grant
  task automatic cycle(output int g);
    g = exp_gnt();
    #1;
    chk("req_ready", req_ready, g < 0 ? 0 : (1 << g));
    chk("rs1_busy", rs1_busy, exp_busy(rs1_idx));
    chk("rs2_busy", rs2_busy, exp_busy(rs2_idx));
    chk("iss_waw", iss_waw, iss_idx != 0 && sb_m[iss_idx]);
`ifdef CORE_WB_BYPASS_EN
    chk("rs1_byp", rs1_byp, exp_byp(rs1_idx));
    chk("rs2_byp", rs2_byp, exp_byp(rs2_idx));
    if (m_wen) chk("byp_dat", byp_dat, m_dat);
`endif
    @(posedge clk);
    if (sb_flush) foreach (sb_m[i]) sb_m[i] = 1'b0;
    else begin
      if (m_wen) sb_m[m_idx] = 1'b0;
      if (iss_valid && iss_idx != 0) sb_m[iss_idx] = 1'b1;
    end
    if (g >= 0) begin
      m_idx = req_idx[g*RW +: RW];
      m_dat = req_dat[g*XLEN +: XLEN];
      m_wen = m_idx != 0;
      rr    = (g + 1) % NREQ;
    end else m_wen = 1'b0;
    #1;
    chk("wb_dest_wen", wb_dest_wen, m_wen);
    chk("wb_dest_idx", wb_dest_idx, m_idx);
    chk("wb_dest_dat", wb_dest_dat, m_dat);
    @(negedge clk);
  endtask

  initial begin
    int g;
    rst = 1'b1; req_valid = '0; req_idx = '0; req_dat = '0;
    iss_valid = 1'b0; iss_idx = '0; sb_flush = 1'b0; rs1_idx = '0; rs2_idx = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_wen", wb_dest_wen, 0);
    chk("rst_idx", wb_dest_idx, 0);
    chk("rst_dat", wb_dest_dat, 0);

    // fairness: all three held valid
    req_valid = 3'b111;
    for (int i = 0; i < NREQ; i++) begin
      req_idx[i*RW +: RW]     = RW'(10 + i);
      req_dat[i*XLEN +: XLEN] = 32'hA000_0000 + i;
    end
    for (int k = 0; k < 6; k++) begin
      cycle(g);
      chk("fair_order", g, k % 3);
    end
    req_valid = '0;
    cycle(g);

    // single request from ALU
    req_valid = 3'b001; req_idx[0 +: RW] = 5'd5; req_dat[0 +: XLEN] = 32'hDEADBEEF;
    cycle(g);
    chk("single_dat", wb_dest_dat, 32'hDEADBEEF);
    req_valid = '0;
    cycle(g);

    // scoreboard set, LSU write clears it
    iss_valid = 1'b1; iss_idx = 5'd7;
    cycle(g);
    iss_valid = 1'b0; rs1_idx = 5'd7;
    cycle(g);
    req_valid = 3'b010; req_idx[RW +: RW] = 5'd7; req_dat[XLEN +: XLEN] = 32'h1234_5678;
    cycle(g);
    req_valid = '0;
    cycle(g);
    cycle(g);
    chk("x7_cleared", rs1_busy, 0);

    // same-edge set and clear on x9, then flush
    iss_valid = 1'b1; iss_idx = 5'd9;
    cycle(g);
    iss_valid = 1'b0; req_valid = 3'b100; req_idx[2*RW +: RW] = 5'd9; req_dat[2*XLEN +: XLEN] = 32'h99;
    cycle(g);
    req_valid = '0; iss_valid = 1'b1; iss_idx = 5'd9;
    cycle(g);
    iss_valid = 1'b0; rs1_idx = 5'd9; rs2_idx = 5'd7;
    cycle(g);
    chk("x9_still_set", rs1_busy, 1);
    iss_valid = 1'b1; iss_idx = 5'd7; sb_flush = 1'b1;
    cycle(g);
    iss_valid = 1'b0; sb_flush = 1'b0;
    cycle(g);
    chk("flush_rs1", rs1_busy, 0);
    chk("flush_rs2", rs2_busy, 0);

    // x0 target: handshaken but never written
    req_valid = 3'b100; req_idx[2*RW +: RW] = 5'd0; req_dat[2*XLEN +: XLEN] = 32'h55;
    iss_valid = 1'b1; iss_idx = 5'd0; rs1_idx = 5'd0;
    cycle(g);
    chk("x0_wen", wb_dest_wen, 0);
    req_valid = '0; iss_valid = 1'b0;
    cycle(g);

    // async reset while a write is on the port and sb is nonzero
    iss_valid = 1'b1; iss_idx = 5'd3;
    cycle(g);
    iss_valid = 1'b0; req_valid = 3'b010; req_idx[RW +: RW] = 5'd3; req_dat[XLEN +: XLEN] = 32'h33;
    cycle(g);
    req_valid = '0; rs1_idx = 5'd3; rs2_idx = 5'd3;
    chk("pre_rst_wen", wb_dest_wen, 1);
    rst = 1'b1;
    #1;
    chk("arst_wen", wb_dest_wen, 0);
    chk("arst_idx", wb_dest_idx, 0);
    chk("arst_dat", wb_dest_dat, 0);
    chk("arst_busy", rs1_busy, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    req_valid = 3'b111;
    cycle(g);
    chk("arst_rr", g, 0);
    req_valid = '0;
    cycle(g);

    // random traffic with held requests
    repeat (300) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req_idx[i*RW +: RW] = RW'($urandom_range(0, 7));
          req_dat[i*XLEN +: XLEN] = $urandom;
        end
      iss_valid = 1'($urandom_range(0, 1));
      iss_idx   = RW'($urandom_range(0, 7));
      rs1_idx   = RW'($urandom_range(0, 7));
      rs2_idx   = RW'($urandom_range(0, 7));
      sb_flush  = $urandom_range(0, 15) == 0;
      cycle(g);
      if (g >= 0) req_valid[g] = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
